// File: rtl/dmem_responder.sv
// Data-memory responder: one RV64I load/store at a time, fixed LATENCY, sign/zero-extended loads.
// Misaligned, out-of-range and illegal-size accesses return rsp_err with zero data and no storage update.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_req_ready;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [63:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_we;
    logic [2:0]  w_f3;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic [AW-1:0] w_idx;
    logic [5:0]  w_sh;
    logic [63:0] w_word;
    logic [63:0] w_shr;
    logic [63:0] w_load;
    logic [7:0]  w_bsel;
    logic [7:0]  w_bmask;
    logic [63:0] w_wsh;
    logic [63:0] w_merged;
    logic        w_misal;
    logic        w_oor;
    logic        w_ill;
    logic        w_err;

    assign w_accept  = req_valid & r_req_ready;
    assign req_ready = r_req_ready;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With LATENCY == 1 the access happens on the acceptance edge, so use the live request.
    assign w_we    = (r_state == S_IDLE) ? req_we     : r_we;
    assign w_f3    = (r_state == S_IDLE) ? req_funct3 : r_f3;
    assign w_addr  = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata  : r_wdata;

    assign w_idx  = w_addr[3+AW-1:3];
    assign w_sh   = {w_addr[2:0], 3'b000};
    assign w_word = r_mem[w_idx];

    assign w_misal = ((w_f3[1:0] == 2'd1) && w_addr[0]) ||
                     ((w_f3[1:0] == 2'd2) && (w_addr[1:0] != 2'd0)) ||
                     ((w_f3[1:0] == 2'd3) && (w_addr[2:0] != 3'd0));
    assign w_oor   = |w_addr[63:3+AW];
    assign w_ill   = w_we ? w_f3[2] : (w_f3 == 3'b111);
    assign w_err   = w_misal | w_oor | w_ill;

    always_comb begin
        w_shr  = w_word >> w_sh;
        w_load = w_shr;
        case (w_f3)
            3'b000:  w_load = {{56{w_shr[7]}},  w_shr[7:0]};
            3'b001:  w_load = {{48{w_shr[15]}}, w_shr[15:0]};
            3'b010:  w_load = {{32{w_shr[31]}}, w_shr[31:0]};
            3'b100:  w_load = {56'd0, w_shr[7:0]};
            3'b101:  w_load = {48'd0, w_shr[15:0]};
            3'b110:  w_load = {32'd0, w_shr[31:0]};
            default: w_load = w_shr;
        endcase
    end

    always_comb begin
        w_bsel = 8'hFF;
        case (w_f3[1:0])
            2'd0:    w_bsel = 8'h01;
            2'd1:    w_bsel = 8'h03;
            2'd2:    w_bsel = 8'h0F;
            default: w_bsel = 8'hFF;
        endcase
        w_bmask  = w_bsel << w_addr[2:0];
        w_wsh    = w_wdata << w_sh;
        w_merged = w_word;
        for (int i = 0; i < 8; i++) begin
            w_merged[i*8 +: 8] = w_bmask[i] ? w_wsh[i*8 +: 8] : w_word[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_we        <= 1'b0;
            r_f3        <= 3'd0;
            r_addr      <= 64'd0;
            r_wdata     <= 64'd0;
            r_rsp_rdata <= 64'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_enter_resp) begin
                r_rsp_rdata <= (w_err | w_we) ? 64'd0 : w_load;
                r_rsp_err   <= w_err;
            end
        end
    end

    // Storage is not reset; reset holds the FSM in IDLE, which blocks any commit.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_we && !w_err) begin
            r_mem[w_idx] <= w_merged;
        end
    end
endmodule
